// File: rtl/instr_encoder.sv
// Encodes symbolic instruction requests into RV64I words and streams them into
// instruction memory at consecutive byte addresses through a small word buffer.
module instr_encoder #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              req_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FILL_W-1:0] fill;
    logic [ADDR_W-1:0] addr_q, count_q;
    logic              err_q;
    logic [31:0]       enc_word;
    logic              enc_bad, i_ok, b_ok;
    logic              fifo_full, fifo_empty, push, pop;

    // Both ports transfer on the rising edge where valid & ready are high; valid
    // never depends on ready, and the write port holds addr/data until taken.
    assign fifo_full  = (fill == FILL_W'(FIFO_DEPTH));
    assign fifo_empty = (fill == '0);
    assign wr_valid   = !fifo_empty;
    assign pop        = wr_valid && wr_ready;
    assign req_ready  = (state == S_RUN) && (!fifo_full || wr_ready);
    assign push       = req_valid && req_ready;
    assign wr_data    = mem[rd_ptr];
    assign wr_addr    = addr_q;
    assign count      = count_q;
    assign err        = err_q;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign dbg_state  = state;

    assign i_ok = ($signed(req_imm) >= -32'sd2048) && ($signed(req_imm) <= 32'sd2047);
    assign b_ok = ($signed(req_imm) >= -32'sd4096) && ($signed(req_imm) <= 32'sd4094) && !req_imm[0];

    always_comb begin
        enc_word = NOP;
        enc_bad  = 1'b0;
        case (req_op)
            4'd0: enc_word = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            4'd1: enc_word = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, 7'b0110011};
            4'd2: enc_word = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, 7'b0110011};
            4'd3: enc_word = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, 7'b0110011};
            4'd4: begin
                enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, 7'b0010011};
                enc_bad  = !i_ok;
            end
            4'd5: begin
                enc_word = {req_imm[11:0], req_rs1, 3'b011, req_rd, 7'b0000011};
                enc_bad  = !i_ok;
            end
            4'd6: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], 7'b0100011};
                enc_bad  = !i_ok;
            end
            4'd7: begin
                enc_word = {req_imm[11:5], req_rs2, req_rs1, 3'b011, req_imm[4:0], 7'b0100011};
                enc_bad  = !i_ok;
            end
            4'd8: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                            req_imm[4:1], req_imm[11], 7'b1100011};
                enc_bad  = !b_ok;
            end
            4'd9: begin
                enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b001,
                            req_imm[4:1], req_imm[11], 7'b1100011};
                enc_bad  = !b_ok;
            end
            default: begin
                enc_word = NOP;
                enc_bad  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= enc_word;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                addr_q  <= addr_q + ADDR_W'(4);
                count_q <= count_q + ADDR_W'(1);
            end
            if (push && !pop)      fill <= fill + FILL_W'(1);
            else if (pop && !push) fill <= fill - FILL_W'(1);
            if (push && enc_bad) err_q <= 1'b1;

            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RUN;
                    addr_q  <= base_addr;
                    count_q <= '0;
                    err_q   <= 1'b0;
                end
                S_RUN:   if (push && req_last) state <= S_DRAIN;
                S_DRAIN: if (fifo_empty) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the pipeline's instruction decoder. It accepts symbolic instruction requests (operation code, register indices, immediate) over a valid/ready stream and encodes each into a 32-bit RV64I word for the subset the core executes. Encoded words pass through a 2-entry buffer and are written sequentially into instruction memory from a programmable base address. It is used by the bench/boot loader to build programs in imem without hand-assembled hex.

Parameters:
ADDR_W, 32, width of imem byte address and write counter
FIFO_DEPTH, 2, encoded-word buffer depth (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin load session (ignored unless IDLE)
base_addr  in  ADDR_W  first imem byte address, sampled on start
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LD, 6 SW, 7 SD, 8 BEQ, 9 BNE, 10-15 illegal
req_rd  in  5  destination register
req_rs1  in  5  source 1
req_rs2  in  5  source 2 (store data / branch compare)
req_imm  in  32  signed immediate; byte offset for branches
req_last  in  1  final request of the session
wr_valid  out  1  imem write pending
wr_ready  in  1  imem accepts write when wr_valid & wr_ready
wr_addr  out  ADDR_W  imem byte address
wr_data  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when session complete
err  out  1  sticky: illegal op or immediate out of range this session
count  out  ADDR_W  words written this session

Behaviour:
- Reset: state IDLE; req_ready, wr_valid, busy, done, err = 0; wr_addr, wr_data, count = 0; FIFO empty.
- FSM: IDLE -start-> RUN (latch base_addr into address counter, clear count and err). RUN: req_ready = !fifo_full; when the accepted request has req_last=1 -> DRAIN. DRAIN: req_ready=0; when FIFO empty and no write pending -> DONE. DONE: done=1 for one cycle -> IDLE.
- start while busy: ignored. req_valid in IDLE/DRAIN/DONE: not accepted (req_ready=0).
- Encoding is combinational on the request and pushed into the FIFO on acceptance; wr_data/wr_valid come from the FIFO head. Minimum latency is one cycle (accept at edge N, wr_valid high after edge N).
- Push and pop in the same cycle are permitted when full; the pop frees the slot the same cycle.
- Formats: R: f7|rs2|rs1|f3|rd|0110011; ADD f3=000 f7=0, SUB f3=000 f7=0100000, AND f3=111, OR f3=110. ADDI: I-type op 0010011 f3=000. LD: I-type op 0000011 f3=011. SW/SD: S-type op 0100011, f3=010/011, imm[11:5]->[31:25], imm[4:0]->[11:7]. BEQ/BNE: B-type op 1100011, f3=000/001, imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
- Unused fields are zero: rd for S/B, rs2 for I.
- Range: I/S need req_imm in [-2048, 2047]; B needs [-4096, 4094] and even. Violation: encode truncated bits anyway and set err.
- Illegal op: emit NOP 0x00000013 and set err.
- Each accepted write: wr_addr += 4 (wraps modulo 2^ADDR_W), count += 1. wr_valid, wr_addr and wr_data hold stable until wr_ready.
- rst_n low mid-session: immediate return to reset values; FIFO contents discarded.

Test Plan:
- start base 0x100; ADD x3,x1,x2 then SUB x3,x1,x2 (last), wr_ready=1 -> writes 0x002081B3 @0x100, 0x402081B3 @0x104; done pulses once; count=2; err=0.
- LD x5,8(x2); SD x5,16(x2); BEQ x1,x2,-4 (last) -> 0x00813283, 0x00513823, 0xFE208EE3 at consecutive addresses.
- wr_ready=0 for 10 cycles during a 4-request stream -> req_ready drops after 2 accepts; no word lost or duplicated; wr_data held stable; order preserved after release.
- req_op=12, then ADDI x1,x0,4096 -> 0x00000013 written, then truncated word written; err=1 after the first and stays set until the next start.
- base_addr=0xFFFFFFFC with 2 requests -> addresses 0xFFFFFFFC then 0x00000000.
- rst_n asserted in DRAIN with 2 words buffered -> wr_valid=0 and state IDLE at once; next start session behaves normally.
